// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types and helpers for the LFSR arbiter slice. Holds the
//               arbiter state encoding, the LFSR width and tap mask, and the
//               single-step LFSR function used by the design and its model.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int         LFSR_W   = 8;
    // Taps at bits 7,5,4,3: feedback = q[7]^q[5]^q[4]^q[3]
    localparam logic [7:0] TAP_MASK = 8'b1011_1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MIX  = 1'b1
    } state_t;

    // One Fibonacci step: shift left, feedback parity enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : 8-bit LFSR register. Synchronous active-low reset to SEED,
//               a parallel load and a single-step enable; load wins over step.
// Ports       : clk_i      - clock
//               rst_ni     - synchronous active-low reset
//               load_i     - load load_val_i this edge
//               load_val_i - value to load (caller guarantees non-zero)
//               step_i     - advance one LFSR step this edge
//               q_o        - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'b1010_1010
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= SEED;
        end else if (load_i) begin
            r_q <= load_val_i;
        end else if (step_i) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_arbiter
// Description : Round-robin arbiter handing out one LFSR byte per grant. After
//               each grant the LFSR is stepped DRAW_STEPS times in total
//               before another grant can issue, so consumers never share bits.
// Ports       : clk_i    - clock
//               rst_ni   - synchronous active-low reset
//               req_i    - per-requester level request
//               gnt_o    - registered one-hot grant pulse
//               rand_o   - random byte, valid with gnt_o, holds otherwise
//               reseed_i - load seed_i into the LFSR (zero maps to SEED)
//               seed_i   - reseed value
//               busy_o   - high while the post-grant mixing is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int                NUM_REQ    = 4,
    parameter logic [LFSR_W-1:0] SEED       = 8'b1010_1010,
    parameter int                DRAW_STEPS = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [LFSR_W-1:0]  rand_o,
    input  logic               reseed_i,
    input  logic [LFSR_W-1:0]  seed_i,
    output logic               busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DRAW_STEPS + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [LFSR_W-1:0]  r_rand;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_gnt_next;
    logic [LFSR_W-1:0]  w_rand_next;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    int                 w_idx;

    logic               w_lfsr_load;
    logic               w_lfsr_step;
    logic [LFSR_W-1:0]  w_lfsr_q;
    logic [LFSR_W-1:0]  w_load_val;

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    assign w_load_val = (seed_i == '0) ? SEED : seed_i;

    lfsr_core #(
        .SEED       (SEED)
    ) u_lfsr_core (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_lfsr_load),
        .load_val_i (w_load_val),
        .step_i     (w_lfsr_step),
        .q_o        (w_lfsr_q)
    );

    // Search upward from the round-robin pointer; the index is wrapped by
    // subtraction so non-power-of-2 NUM_REQ never points past the last bit.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_i[PTR_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_gnt_next   = '0;
        w_rand_next  = r_rand;
        w_lfsr_load  = 1'b0;
        w_lfsr_step  = 1'b0;

        if (reseed_i) begin
            w_lfsr_load  = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_gnt_next  = NUM_REQ'(1) << w_winner;
                        w_rand_next = w_lfsr_q;
                        w_lfsr_step = 1'b1;
                        w_ptr_next  = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                                       : w_winner + 1'b1;
                        // The grant edge itself is the first of DRAW_STEPS steps.
                        if (DRAW_STEPS > 1) begin
                            w_state_next = MIX;
                            w_cnt_next   = CNT_W'(DRAW_STEPS - 1);
                        end
                    end
                end
                MIX: begin
                    w_lfsr_step = 1'b1;
                    w_cnt_next  = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_rand  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_gnt   <= w_gnt_next;
            r_rand  <= w_rand_next;
        end
    end

    assign gnt_o  = r_gnt;
    assign rand_o = r_rand;
    assign busy_o = (r_state == MIX);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_arbiter
// Description : Self-checking bench for lfsr_arbiter. A time-based reference
//               model (grant allowed once DRAW_STEPS cycles have elapsed, LFSR
//               advanced DRAW_STEPS steps per grant) checks every cycle; a
//               second instance with DRAW_STEPS=1 covers back-to-back grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_arbiter;
    import lfsr_pkg::*;

    localparam int         NUM_REQ = 4;
    localparam int         DRAW    = 8;
    localparam logic [7:0] SEED    = 8'hAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (DRAW_STEPS = 8)
    logic               rst_n;
    logic               reseed;
    logic [7:0]         seed;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [7:0]         rnd;
    logic               busy;

    // Back-to-back instance (DRAW_STEPS = 1)
    logic               rst1_n;
    logic               reseed1;
    logic [7:0]         seed1;
    logic [NUM_REQ-1:0] req1;
    logic [NUM_REQ-1:0] gnt1;
    logic [7:0]         rnd1;
    logic               busy1;

    lfsr_arbiter #(.NUM_REQ(NUM_REQ), .SEED(SEED), .DRAW_STEPS(DRAW)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .rand_o(rnd),
        .reseed_i(reseed), .seed_i(seed), .busy_o(busy)
    );

    lfsr_arbiter #(.NUM_REQ(NUM_REQ), .SEED(SEED), .DRAW_STEPS(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .req_i(req1), .gnt_o(gnt1), .rand_o(rnd1),
        .reseed_i(reseed1), .seed_i(seed1), .busy_o(busy1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                 m_cycle = 0;
    int                 m_until = 0;   // first edge index at which a grant may issue
    int                 m_ptr   = 0;
    logic [7:0]         m_lfsr  = SEED;
    logic [7:0]         m_rand  = '0;
    logic [NUM_REQ-1:0] m_gnt   = '0;
    logic               m_busy  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One clock edge on the main instance: update model, then compare outputs.
    task automatic tick();
        int w;
        int idx;
        @(posedge clk);
        m_gnt = '0;
        if (!rst_n) begin
            m_lfsr  = SEED;
            m_rand  = '0;
            m_ptr   = 0;
            m_until = m_cycle;
        end else if (reseed) begin
            m_lfsr  = (seed == 8'h00) ? SEED : seed;
            m_until = m_cycle;
        end else if (m_cycle >= m_until && req != '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (w < 0 && req[idx]) w = idx;
            end
            m_gnt  = NUM_REQ'(1 << w);
            m_rand = m_lfsr;
            for (int s = 0; s < DRAW; s++) m_lfsr = lfsr_step(m_lfsr);
            m_ptr   = (w + 1) % NUM_REQ;
            m_until = m_cycle + DRAW;
        end
        m_busy = (m_cycle + 1 < m_until);
        m_cycle++;
        #1;
        check("gnt",  8'(gnt),  8'(m_gnt));
        check("rand", rnd,      m_rand);
        check("busy", 8'(busy), 8'(m_busy));
    endtask

    // Tick until a grant appears or the bound expires; n = ticks taken.
    task automatic wait_grant(input string tag, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < limit);
        check(tag, 8'(gnt != '0), 8'd1);
    endtask

    initial begin
        int         n;
        int         busy_cnt;
        logic [7:0] exp_b;
        logic [NUM_REQ-1:0] rr_order [5];

        rst_n = 1'b0; reseed = 1'b0; seed = '0; req = '0;
        rst1_n = 1'b0; reseed1 = 1'b0; seed1 = '0; req1 = '0;

        // Reset state
        tick();
        check("rst_gnt",  8'(gnt),  8'h00);
        check("rst_rand", rnd,      8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        rst_n = 1'b1;

        // Single requester: grant one cycle later with SEED, then 8-cycle spacing
        req = 4'b0001;
        tick();
        check("single_gnt0",  8'(gnt), 8'h01);
        check("single_rand0", rnd,     8'hAA);
        busy_cnt = int'(busy);
        for (int i = 0; i < DRAW - 1; i++) begin
            tick();
            busy_cnt += int'(busy);
        end
        check("single_busy_cycles", 8'(busy_cnt), 8'd7);
        tick();
        exp_b = 8'hAA;
        for (int s = 0; s < DRAW; s++) exp_b = lfsr_step(exp_b);
        check("single_gnt1",  8'(gnt), 8'h01);
        check("single_rand1", rnd,     exp_b);

        // Round-robin with all requesting, from a fresh pointer
        rst_n = 1'b0; req = '0;
        tick();
        rst_n = 1'b1; req = 4'b1111;
        rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr_seen", 20, n);
            check("rr_gnt",     8'(gnt), 8'(rr_order[g]));
            check("rr_spacing", 8'(n),   (g == 0) ? 8'd1 : 8'd8);
        end
        wait_grant("rr_seen", 20, n);
        check("rr_gnt_bit1", 8'(gnt), 8'h02);
        req = 4'b1010;
        wait_grant("rr_seen", 20, n);
        check("rr_skip_bit3", 8'(gnt), 8'h08);
        wait_grant("rr_seen", 20, n);
        check("rr_back_bit1", 8'(gnt), 8'h02);

        // Reseed in the same cycle as a request in IDLE
        req = '0;
        repeat (DRAW) tick();
        req = 4'b0001; reseed = 1'b1; seed = 8'h3C;
        tick();
        check("reseed_no_gnt", 8'(gnt), 8'h00);
        reseed = 1'b0;
        tick();
        check("reseed_gnt",  8'(gnt), 8'h01);
        check("reseed_rand", rnd,      8'h3C);

        // Zero seed substitutes SEED
        req = '0;
        repeat (DRAW) tick();
        reseed = 1'b1; seed = 8'h00;
        tick();
        reseed = 1'b0; req = 4'b0001;
        tick();
        check("zero_seed_rand", rnd, 8'hAA);

        // Reseed three cycles into MIX
        req = '0;
        tick();
        tick();
        check("mid_mix_busy_before", 8'(busy), 8'h01);
        req = 4'b0001; reseed = 1'b1; seed = 8'h55;
        tick();
        check("mid_mix_busy_drop", 8'(busy), 8'h00);
        check("mid_mix_no_gnt",    8'(gnt),  8'h00);
        reseed = 1'b0;
        tick();
        check("mid_mix_gnt",  8'(gnt), 8'h01);
        check("mid_mix_rand", rnd,     8'h55);

        // Reset during MIX
        req = '0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_mix_gnt",  8'(gnt),  8'h00);
        check("rst_mix_rand", rnd,      8'h00);
        check("rst_mix_busy", 8'(busy), 8'h00);
        rst_n = 1'b1; req = 4'b0101;
        tick();
        check("rst_mix_gnt_after",  8'(gnt), 8'h01);
        check("rst_mix_rand_after", rnd,     8'hAA);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            reseed = ($urandom_range(0, 19) == 0);
            seed   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            req    = NUM_REQ'($urandom);
            tick();
        end
        rst_n = 1'b1; reseed = 1'b0; req = '0;

        // DRAW_STEPS = 1: back-to-back alternating grants
        check("ds1_rst_gnt", 8'(gnt1), 8'h00);
        rst1_n = 1'b1; req1 = 4'b0011;
        @(posedge clk); #1;
        check("ds1_gnt0",  8'(gnt1),  8'h01);
        check("ds1_rand0", rnd1,      8'hAA);
        check("ds1_busy0", 8'(busy1), 8'h00);
        @(posedge clk); #1;
        check("ds1_gnt1",  8'(gnt1),  8'h02);
        check("ds1_rand1", rnd1,      8'h55);
        @(posedge clk); #1;
        check("ds1_gnt2",  8'(gnt1),  8'h01);
        check("ds1_rand2", rnd1,      8'hAB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
